gost_magma_engine: RTL and testbench

Parametrised successor to the single-mode GOST 28147-89 core: a 64-bit block engine with a configurable number of rounds per clock, per-block encrypt/decrypt selection, optional CBC chaining, and valid/ready handshakes on input and output. It sits between the top-level pin wrapper, which serialises key and data, and the downstream output formatter. It replaces the fixed load/done interface of the earlier core.

---
 rtl/gost_magma_engine.sv | 174 +++++++++++++++++
 tb/tb_gost_magma_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost_magma_engine.sv
`default_nettype none
// ============================================================================
// gost_magma_engine: Magma (GOST 28147-89) 64-bit block engine, ECB/CBC, valid/ready
// Revision 1.0
// ============================================================================
module gost_magma_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit CBC_EN           = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [255:0] key,
    input  logic         iv_load,
    input  logic [63:0]  iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic         in_cbc,
    input  logic [63:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam logic [4:0] ROUND_STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_ROUND = 5'(32 - ROUNDS_PER_CYCLE);

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rounds
        $error("gost_magma_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           key_ok;
    logic [255:0]   key_q;
    logic [63:0]    chain;
    logic [63:0]    blk_q;
    logic [63:0]    out_q;
    logic [31:0]    a1_q;
    logic [31:0]    a0_q;
    logic [4:0]     round_q;
    logic           dec_q;
    logic           cbc_q;
    logic [63:0]    result;
    logic [31:0]    a1_w [ROUNDS_PER_CYCLE+1];
    logic [31:0]    a0_w [ROUNDS_PER_CYCLE+1];

    // t = half + k, S-box substitution per nibble, rotate left by 11
    function automatic logic [31:0] round_f(input logic [31:0] half, input logic [31:0] subkey);
        logic [31:0] t;
        logic [31:0] s;
        t = half + subkey;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            s[4*n +: 4] = SBOX[n][t[4*n +: 4]];
        end
        return {s[20:0], s[31:21]};
    endfunction

    assign a1_w[0] = a1_q;
    assign a0_w[0] = a0_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [4:0]  idx;
        logic        rev;
        logic [2:0]  kidx;
        logic [31:0] subkey;
        assign idx    = round_q + 5'(j);
        // encrypt reverses the key order in the last quarter, decrypt in all but the first
        assign rev    = dec_q ? (idx[4:3] != 2'b00) : (idx[4:3] == 2'b11);
        assign kidx   = rev ? ~idx[2:0] : idx[2:0];
        assign subkey = key_q[{~kidx, 5'b0} +: 32];
        assign a1_w[j+1] = a0_w[j];
        assign a0_w[j+1] = a1_w[j] ^ round_f(a0_w[j], subkey);
    end

    // undo the swap of the final round; CBC decrypt folds in the chain value
    assign result = {a0_w[ROUNDS_PER_CYCLE], a1_w[ROUNDS_PER_CYCLE]}
                  ^ ((cbc_q && dec_q) ? chain : 64'h0);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = key_ok;
                accept   = key_ok && in_valid && !key_load;
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (round_q == LAST_ROUND) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_ok  <= 1'b0;
            key_q   <= '0;
            chain   <= '0;
            blk_q   <= '0;
            out_q   <= '0;
            a1_q    <= '0;
            a0_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            cbc_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (key_load) begin
                        key_q  <= key;
                        key_ok <= 1'b1;
                    end
                    if (iv_load && CBC_EN) chain <= iv;
                    if (accept) begin
                        {a1_q, a0_q} <= (CBC_EN && in_cbc && !in_decrypt) ? (in_data ^ chain) : in_data;
                        blk_q   <= in_data;
                        dec_q   <= in_decrypt;
                        cbc_q   <= in_cbc && CBC_EN;
                        round_q <= '0;
                    end
                end
                RUN: begin
                    a1_q    <= a1_w[ROUNDS_PER_CYCLE];
                    a0_q    <= a0_w[ROUNDS_PER_CYCLE];
                    round_q <= round_q + ROUND_STEP;
                    if (round_q == LAST_ROUND) begin
                        out_q <= result;
                        if (cbc_q) chain <= dec_q ? blk_q : result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_q;

endmodule
`default_nettype wire

// File: tb/tb_gost_magma_engine.sv
`default_nettype none
// tb_gost_magma_engine: two engines (R=1 with CBC, R=8 ECB-only) checked against a Magma model.
`timescale 1ns/1ps
module tb_gost_magma_engine;

    localparam logic [255:0] KEY0 = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  PT   = 64'hfedcba9876543210;
    localparam logic [63:0]  CT   = 64'h4ee901e5c2d8ca3d;

    localparam bit [3:0] SB [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_n, key_load, iv_load, in_valid, in_decrypt, in_cbc, out_ready;
    logic [1:0]   in_ready, out_valid, busy;
    logic [255:0] key [2];
    logic [63:0]  iv [2];
    logic [63:0]  in_data [2];
    logic [63:0]  out_data [2];

    gost_magma_engine #(.ROUNDS_PER_CYCLE(1), .CBC_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .key_load(key_load[0]), .key(key[0]),
        .iv_load(iv_load[0]), .iv(iv[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_decrypt(in_decrypt[0]), .in_cbc(in_cbc[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    gost_magma_engine #(.ROUNDS_PER_CYCLE(8), .CBC_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .key_load(key_load[1]), .key(key[1]),
        .iv_load(iv_load[1]), .iv(iv[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_decrypt(in_decrypt[1]), .in_cbc(in_cbc[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    // model state per engine
    logic [255:0] mkey [2];
    logic [63:0]  mchain [2];
    bit           cbc_cap [2] = '{1'b1, 1'b0};
    int           nlat [2]    = '{32, 4};

    typedef struct {
        bit          dec;
        bit          cbc;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Magma block cipher straight from the algorithm description
    function automatic logic [63:0] magma(input logic [255:0] k, input logic [63:0] blk, input bit dec);
        int          ks [32];
        logic [31:0] a1, a0, t, s, nxt;
        for (int r = 0; r < 32; r++) begin
            if (!dec) ks[r] = (r < 24) ? (r % 8) : (7 - r % 8);
            else      ks[r] = (r < 8)  ? r       : (7 - r % 8);
        end
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int r = 0; r < 32; r++) begin
            t = a0 + k[255 - 32*ks[r] -: 32];
            for (int n = 0; n < 8; n++) s[4*n +: 4] = SB[n][t[4*n +: 4]];
            nxt = a1 ^ ((s << 11) | (s >> 21));
            a1  = a0;
            a0  = nxt;
        end
        return {a0, a1};
    endfunction

    task automatic model(input int d, input bit dec, input bit cbc, input logic [63:0] din,
                         output logic [63:0] exp);
        bit use_chain;
        use_chain = cbc && cbc_cap[d];
        if (!dec) begin
            exp = magma(mkey[d], use_chain ? (din ^ mchain[d]) : din, 1'b0);
            if (use_chain) mchain[d] = exp;
        end else begin
            exp = magma(mkey[d], din, 1'b1);
            if (use_chain) begin
                exp = exp ^ mchain[d];
                mchain[d] = din;
            end
        end
    endtask

    task automatic load_key(input int d, input logic [255:0] k);
        @(negedge clk);
        key_load[d] = 1'b1;
        key[d] = k;
        @(negedge clk);
        key_load[d] = 1'b0;
        mkey[d] = k;
    endtask

    task automatic load_iv(input int d, input logic [63:0] v);
        @(negedge clk);
        iv_load[d] = 1'b1;
        iv[d] = v;
        @(negedge clk);
        iv_load[d] = 1'b0;
        if (cbc_cap[d]) mchain[d] = v;
    endtask

    task automatic wait_ready(input int d);
        int w = 0;
        while (!in_ready[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 64'(in_ready[d]), 64'd1);
    endtask

    // one block: accept, measure latency, optional backpressure, consume
    task automatic run_block(input int d, input bit dec, input bit cbc, input logic [63:0] din,
                             input int hold, output logic [63:0] dout);
        logic [63:0] exp;
        int lat;
        model(d, dec, cbc, din, exp);
        wait_ready(d);
        in_valid[d] = 1'b1;
        in_decrypt[d] = dec;
        in_cbc[d] = cbc;
        in_data[d] = din;
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d] = {$urandom, $urandom};
        in_cbc[d] = $urandom_range(0, 1) != 0;
        check("busy_after_accept", 64'(busy[d]), 64'd1);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(nlat[d]));
        check("out_data", out_data[d], exp);
        dout = out_data[d];
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = (i % 2) == 0;
            @(negedge clk);
            check("bp_out_stable", out_data[d], dout);
            check("bp_in_ready", 64'(in_ready[d]), 64'd0);
            check("bp_out_valid", 64'(out_valid[d]), 64'd1);
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check("consumed_out_valid", 64'(out_valid[d]), 64'd0);
        check("consumed_in_ready", 64'(in_ready[d]), 64'd1);
        check("consumed_busy", 64'(busy[d]), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  dout, c1, c2;
        logic [255:0] rkey;
        int           w;

        rst_n = 2'b00; key_load = '0; iv_load = '0; in_valid = '0;
        in_decrypt = '0; in_cbc = '0; out_ready = '0;
        for (int d = 0; d < 2; d++) begin
            key[d] = '0; iv[d] = '0; in_data[d] = '0; mkey[d] = '0; mchain[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 2'b11;

        for (int d = 0; d < 2; d++) begin
            check("reset_in_ready", 64'(in_ready[d]), 64'd0);
            check("reset_out_valid", 64'(out_valid[d]), 64'd0);
            check("reset_busy", 64'(busy[d]), 64'd0);
            check("reset_out_data", out_data[d], 64'd0);
        end

        // no acceptance before a key is loaded
        in_valid = 2'b11;
        in_data[0] = PT;
        in_data[1] = PT;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nokey_busy0", 64'(busy[0]), 64'd0);
            check("nokey_busy1", 64'(busy[1]), 64'd0);
        end
        in_valid = 2'b00;

        load_key(0, KEY0);
        load_key(1, KEY0);
        check("keyed_in_ready0", 64'(in_ready[0]), 64'd1);
        check("keyed_in_ready1", 64'(in_ready[1]), 64'd1);

        // key_load in the same cycle as in_valid: block is not taken
        key_load[1] = 1'b1;
        key[1] = KEY0;
        in_valid[1] = 1'b1;
        @(negedge clk);
        key_load[1] = 1'b0;
        in_valid[1] = 1'b0;
        check("keyload_vs_valid_busy", 64'(busy[1]), 64'd0);
        check("keyload_vs_valid_ready", 64'(in_ready[1]), 64'd1);

        tbl[0] = '{dec: 1'b0, cbc: 1'b0, din: PT, exp: CT};
        tbl[1] = '{dec: 1'b1, cbc: 1'b0, din: CT, exp: PT};
        tbl[2] = '{dec: 1'b0, cbc: 1'b1, din: PT, exp: CT};
        tbl[3] = '{dec: 1'b1, cbc: 1'b0, din: CT, exp: PT};
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                run_block(d, tbl[i].dec, tbl[i].cbc, tbl[i].din, 0, dout);
                check("tbl_vector", dout, tbl[i].exp);
            end
        end

        // backpressure with in_valid pulses during DONE
        run_block(0, 1'b0, 1'b0, PT, 10, dout);
        check("bp_vector0", dout, CT);
        run_block(1, 1'b1, 1'b0, CT, 10, dout);
        check("bp_vector1", dout, PT);

        // CBC round trip with iv=0
        load_iv(0, 64'h0);
        run_block(0, 1'b0, 1'b1, PT, 0, c1);
        check("cbc_c1", c1, CT);
        run_block(0, 1'b0, 1'b1, 64'h0, 0, c2);
        load_iv(0, 64'h0);
        run_block(0, 1'b1, 1'b1, c1, 0, dout);
        check("cbc_p1", dout, PT);
        run_block(0, 1'b1, 1'b1, c2, 0, dout);
        check("cbc_p2", dout, 64'h0);

        // key_load during RUN is ignored
        wait_ready(0);
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_cbc[0] = 1'b0; in_data[0] = PT;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        key_load[0] = 1'b1;
        key[0] = {8{$urandom}};
        iv_load[0] = 1'b1;
        iv[0] = {$urandom, $urandom};
        @(negedge clk);
        key_load[0] = 1'b0;
        iv_load[0] = 1'b0;
        w = 0;
        while (!out_valid[0] && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("runkey_out_valid", 64'(out_valid[0]), 64'd1);
        check("runkey_vector", out_data[0], CT);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        run_block(0, 1'b0, 1'b0, PT, 0, dout);
        check("runkey_next_vector", dout, CT);

        // randomized blocks against the model
        for (int d = 0; d < 2; d++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            load_key(d, rkey);
            load_iv(d, {$urandom, $urandom});
            for (int i = 0; i < 12; i++) begin
                run_block(d, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                          {$urandom, $urandom}, $urandom_range(0, 2), dout);
            end
        end

        // reset in the middle of RUN
        wait_ready(0);
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_cbc[0] = 1'b0; in_data[0] = PT;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        mchain[0] = '0;
        check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_in_ready", 64'(in_ready[0]), 64'd0);
        check("midrst_busy", 64'(busy[0]), 64'd0);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_nokey_busy", 64'(busy[0]), 64'd0);
        end
        in_valid[0] = 1'b0;
        load_key(0, KEY0);
        run_block(0, 1'b0, 1'b0, PT, 0, dout);
        check("midrst_vector", dout, CT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
